poly_tobytes: RTL and testbench

Serializes a 512-coefficient NewHope polynomial from the polynomial RAM into the packed 14-bit-per-coefficient byte array used for public keys and ciphertexts. It sits at the opposite end of the polynomial RAM from the uniform sampler. The sampler writes 16-bit coefficients below 5q; this block reads them back, fully reduces each to [0,q), and writes 7 bytes per 4 coefficients into a byte-wide output RAM. One `start` pulse converts one whole polynomial; `done` pulses when the last byte has been written.

---
 rtl/poly_tobytes.sv | 133 +++++++++++++
 tb/tb_poly_tobytes.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/poly_tobytes.sv
// Packs a 512/1024-coefficient polynomial into 14-bit-per-coefficient bytes, 7 bytes per 4 coefficients.
// Optional full reduction of each coefficient to [0,Q) is compiled in with POLY_TOBYTES_FREEZE_EN.
module poly_tobytes #(
  parameter int N  = 512,
  parameter int Q  = 12289,
  parameter int AW = 9,
  parameter int BW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          range_err,
  output logic [AW-1:0] poly_addr,
  input  logic [15:0]   poly_do,
  output logic          byte_we,
  output logic [BW-1:0] byte_addr,
  output logic [7:0]    byte_di
);

  localparam int GW = AW - 2;
  localparam logic [GW-1:0] LAST_GRP = GW'(N / 4 - 1);

  typedef enum logic [1:0] {IDLE, READ, EMIT, DONE} state_t;

  state_t        state, state_nx;
  logic [GW-1:0] grp;
  logic [2:0]    step;
  logic [13:0]   t [4];
  logic [13:0]   red_val;
  logic          red_err;

  // Coefficient reduction applied to the RAM read data as it is captured
  always_comb begin
    red_val = '0;
    red_err = 1'b0;
`ifdef POLY_TOBYTES_FREEZE_EN
    begin
      logic [15:0] frz;
      frz = poly_do;
      for (int i = 0; i < 4; i++) begin
        if (frz >= 16'(Q)) frz = frz - 16'(Q);
      end
      red_val = frz[13:0];
      red_err = (frz >= 16'(Q));
    end
`else
    red_val = poly_do[13:0];
    red_err = (poly_do[15:14] != 2'b00) || (poly_do[13:0] >= 14'(Q));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    poly_addr = '0;
    byte_we   = 1'b0;
    byte_addr = '0;
    byte_di   = '0;
    case (state)
      IDLE: begin
        if (start) state_nx = READ;
      end
      READ: begin
        busy = 1'b1;
        if (step < 3'd4) poly_addr = {grp, step[1:0]};
        if (step == 3'd4) state_nx = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        byte_we   = 1'b1;
        byte_addr = BW'({grp, 3'b000}) - BW'(grp) + BW'(step);
        case (step)
          3'd0:    byte_di = t[0][7:0];
          3'd1:    byte_di = {t[1][1:0], t[0][13:8]};
          3'd2:    byte_di = t[1][9:2];
          3'd3:    byte_di = {t[2][3:0], t[1][13:10]};
          3'd4:    byte_di = t[2][11:4];
          3'd5:    byte_di = {t[3][5:0], t[2][13:12]};
          3'd6:    byte_di = t[3][13:6];
          default: byte_di = '0;
        endcase
        if (step == 3'd6) state_nx = (grp == LAST_GRP) ? DONE : READ;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read data arrives one cycle after its address, so step k captures coefficient k-1
  always_ff @(posedge clk) begin
    if (rst) begin
      grp       <= '0;
      step      <= '0;
      range_err <= 1'b0;
      for (int i = 0; i < 4; i++) t[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            range_err <= 1'b0;
            grp       <= '0;
            step      <= '0;
          end
        end
        READ: begin
          if (step != 3'd0) begin
            t[2'(step - 3'd1)] <= red_val;
            range_err          <= range_err | red_err;
          end
          step <= (step == 3'd4) ? 3'd0 : step + 3'd1;
        end
        EMIT: begin
          step <= (step == 3'd6) ? 3'd0 : step + 3'd1;
          if (step == 3'd6 && grp != LAST_GRP) grp <= grp + GW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_tobytes.sv
// Self-checking bench for poly_tobytes: a byte-array model of the packing plus a per-cycle timing compare.
// Honours POLY_TOBYTES_FREEZE_EN the same way as the design.
module tb_poly_tobytes;

  localparam int N     = 512;
  localparam int Q     = 12289;
  localparam int AW    = 9;
  localparam int BW    = 10;
  localparam int NB    = 7 * N / 4;
  localparam int LASTC = 12 * N / 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          busy, done, range_err, byte_we;
  logic [AW-1:0] poly_addr;
  logic [15:0]   poly_do;
  logic [BW-1:0] byte_addr;
  logic [7:0]    byte_di;

  logic [15:0] mem [N];
  logic [7:0]  exp_bytes [NB];
  logic        exp_err;

  int checks = 0;
  int errors = 0;

  logic cmp_en  = 1'b0;
  logic run_on  = 1'b0;
  logic aborted = 1'b0;
  int   cyc, abort_cyc, writes;

  poly_tobytes #(.N(N), .Q(Q), .AW(AW), .BW(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .range_err(range_err), .poly_addr(poly_addr), .poly_do(poly_do),
    .byte_we(byte_we), .byte_addr(byte_addr), .byte_di(byte_di)
  );

  always #5 clk = ~clk;

  always @(posedge clk) poly_do <= mem[poly_addr];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value a coefficient must pack to, and whether it must raise range_err
  function automatic logic [13:0] model_coef(input logic [15:0] x, output logic bad);
    int v;
    v = int'(x);
`ifdef POLY_TOBYTES_FREEZE_EN
    if (v < 5 * Q) begin
      v   = v % Q;
      bad = 1'b0;
    end else begin
      v   = v - 4 * Q;
      bad = 1'b1;
    end
`else
    bad = (v >= Q);
    v   = v % 16384;
`endif
    return 14'(v);
  endfunction

  task automatic build_model();
    longint unsigned w;
    logic bad;
    exp_err = 1'b0;
    for (int g = 0; g < N / 4; g++) begin
      w = 0;
      for (int k = 0; k < 4; k++) begin
        w = w | (longint'(model_coef(mem[4 * g + k], bad)) << (14 * k));
        exp_err = exp_err | bad;
      end
      for (int b = 0; b < 7; b++) exp_bytes[7 * g + b] = 8'(w >> (8 * b));
    end
  endtask

  // Cycle 0 is the cycle in which start is sampled; cycles 1..1537 follow from the group schedule
  always @(negedge clk) begin
    if (cmp_en) begin
      if (!run_on) begin
        check_output("idle_outputs", {2'b0, busy, done, byte_we, poly_addr, byte_addr, byte_di}, 32'd0);
        if (start) begin
          run_on  = 1'b1;
          cyc     = 0;
          aborted = 1'b0;
          writes  = 0;
        end
      end else begin
        cyc++;
        if (aborted) begin
          check_output($sformatf("abort_cyc%0d", cyc),
                       {1'b0, range_err, busy, done, byte_we, poly_addr, byte_addr, byte_di}, 32'd0);
          if (cyc >= abort_cyc + 10) run_on = 1'b0;
        end else begin
          logic [31:0] exp;
          int ph, g;
          exp = 32'd0;
          ph  = (cyc - 1) % 12;
          g   = (cyc - 1) / 12;
          if (cyc >= 1 && cyc <= LASTC) begin
            exp[29] = 1'b1;
            if (ph < 4) exp[26:18] = 9'(4 * g + ph);
            if (ph >= 5) begin
              exp[27]    = 1'b1;
              exp[17:8]  = 10'(7 * g + ph - 5);
              exp[7:0]   = exp_bytes[7 * g + ph - 5];
            end
          end else if (cyc == LASTC + 1) begin
            exp[29] = 1'b1;
            exp[28] = 1'b1;
          end
          check_output($sformatf("cyc%0d", cyc),
                       {2'b0, busy, done, byte_we, poly_addr, byte_addr, byte_di}, exp);
          if (byte_we === 1'b1) writes++;
          if (cyc == 1) check_output("range_err_cleared", {31'd0, range_err}, 32'd0);
          if (cyc >= LASTC + 1) check_output($sformatf("range_err_cyc%0d", cyc), {31'd0, range_err}, {31'd0, exp_err});
          if (cyc == LASTC + 4) begin
            check_output("write_count", writes, NB);
            run_on = 1'b0;
          end
        end
        if (rst && !aborted && run_on) begin
          aborted   = 1'b1;
          abort_cyc = cyc;
        end
      end
    end
  end

  task automatic apply_stimulus(input int restart_at, input int rst_at);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    for (int c = 1; c <= LASTC + 6; c++) begin
      if (c == restart_at) start = 1'b1;
      if (c == rst_at) rst = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      rst   = 1'b0;
      if (c == rst_at) begin
        repeat (15) @(posedge clk);
        #2;
        break;
      end
    end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < N; i++) mem[i] = v;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill(16'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_output("reset_range_err", {31'd0, range_err}, 32'd0);
    cmp_en = 1'b1;

    $display("[TB] all-zero polynomial");
    build_model();
    check_output("model_zero_byte", {24'd0, exp_bytes[NB-1]}, 32'd0);
    apply_stimulus(0, 0);

    $display("[TB] coefficients 1,2,3,4");
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
    build_model();
    check_output("model_b0", {24'd0, exp_bytes[0]}, 32'h01);
    check_output("model_b1", {24'd0, exp_bytes[1]}, 32'h80);
    check_output("model_b3", {24'd0, exp_bytes[3]}, 32'h30);
    check_output("model_b5", {24'd0, exp_bytes[5]}, 32'h10);
    check_output("model_b6", {24'd0, exp_bytes[6]}, 32'h00);
    apply_stimulus(0, 0);

    $display("[TB] all coefficients 5Q-1");
    fill(16'd61444);
    build_model();
`ifdef POLY_TOBYTES_FREEZE_EN
    check_output("model_5q_b1", {24'd0, exp_bytes[1]}, 32'h30);
    check_output("model_5q_b3", {24'd0, exp_bytes[3]}, 32'h0C);
    check_output("model_5q_b5", {24'd0, exp_bytes[5]}, 32'h03);
    check_output("model_5q_b6", {24'd0, exp_bytes[NB-1]}, 32'hC0);
    check_output("model_5q_err", {31'd0, exp_err}, 32'd0);
`endif
    apply_stimulus(0, 0);

    $display("[TB] coefficient 5 = 65535");
    fill(16'd0);
    mem[5] = 16'hFFFF;
    build_model();
    check_output("model_ffff_err", {31'd0, exp_err}, 32'd1);
`ifdef POLY_TOBYTES_FREEZE_EN
    check_output("model_ffff_b7", {24'd0, exp_bytes[7]}, 32'h00);
    check_output("model_ffff_b8", {24'd0, exp_bytes[8]}, 32'hC0);
    check_output("model_ffff_b9", {24'd0, exp_bytes[9]}, 32'hFE);
    check_output("model_ffff_b10", {24'd0, exp_bytes[10]}, 32'h0F);
`endif
    apply_stimulus(0, 0);

    $display("[TB] start re-pulsed mid-run");
    fill(16'd0);
    mem[N-1] = 16'd12288;
    build_model();
    apply_stimulus(300, 0);

    $display("[TB] reset mid-run then fresh start");
    fill(16'd0);
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
    mem[100] = 16'd777;
    build_model();
    apply_stimulus(0, 700);
    apply_stimulus(0, 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
